// File: rtl/psum_accum_wb.sv
// rtl/psum_accum_wb.sv - psum write-back stage: direct write or read-accumulate-write into pmem
// Saturating per-lane accumulate with optional ReLU on the final pass.
module psum_accum_wb #(
    parameter int psum_bw    = 16,
    parameter int col        = 8,
    parameter int addr_width = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [addr_width-1:0]     num_vec,
    input  logic [addr_width-1:0]     base_addr,
    input  logic                      first_pass,
    input  logic                      last_pass,
    input  logic                      in_valid,
    input  logic [psum_bw*col-1:0]    in_data,
    output logic                      in_ready,
    output logic                      pmem_cen,
    output logic                      pmem_wen,
    output logic [addr_width-1:0]     pmem_addr,
    output logic [psum_bw*col-1:0]    pmem_d,
    input  logic [psum_bw*col-1:0]    pmem_q,
    output logic                      busy,
    output logic                      done
);

    localparam int dw = psum_bw * col;
    localparam logic [addr_width-1:0] addr_one = 1;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        RD,
        WR,
        FIN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [addr_width-1:0]   num_r;
    logic [addr_width-1:0]   base_r;
    logic                    first_r;
    logic                    last_r;
    logic [addr_width-1:0]   idx_r;
    logic [dw-1:0]           vec_r;
    logic [dw-1:0]           wb_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_vec == '0) ? FIN : ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_valid && in_ready) begin
                    state_next = first_r ? WR : RD;
                end
            end
            RD: begin
                state_next = WR;
            end
            WR: begin
                state_next = (idx_r == num_r - addr_one) ? FIN : ACCEPT;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from state_next so the pins line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            num_r     <= '0;
            base_r    <= '0;
            first_r   <= 1'b0;
            last_r    <= 1'b0;
            idx_r     <= '0;
            vec_r     <= '0;
            in_ready  <= 1'b0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                num_r   <= num_vec;
                base_r  <= base_addr;
                first_r <= first_pass;
                last_r  <= last_pass;
                idx_r   <= '0;
            end
            if (state == ACCEPT && in_valid && in_ready) begin
                vec_r <= in_data;
            end
            if (state == WR) begin
                idx_r <= idx_r + addr_one;
            end
            in_ready <= (state_next == ACCEPT);
            pmem_cen <= !(state_next == RD || state_next == WR);
            pmem_wen <= (state_next != WR);
            if (state_next == RD || state_next == WR) begin
                pmem_addr <= base_r + idx_r;
            end
            busy <= (state_next != IDLE);
            done <= (state_next == FIN);
        end
    end

    for (genvar k = 0; k < col; k++) begin : g_lane
        logic signed [psum_bw-1:0] lane_a;
        logic signed [psum_bw-1:0] lane_b;
        logic signed [psum_bw:0]   lane_sum;
        logic signed [psum_bw-1:0] lane_sat;

        assign lane_a   = vec_r[k*psum_bw +: psum_bw];
        assign lane_b   = first_r ? '0 : pmem_q[k*psum_bw +: psum_bw];
        assign lane_sum = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
        // Overflow shows up as the two top bits of the widened sum disagreeing.
        assign lane_sat = (lane_sum[psum_bw] != lane_sum[psum_bw-1])
                        ? (lane_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                             : {1'b0, {(psum_bw-1){1'b1}}})
                        : lane_sum[psum_bw-1:0];
        assign wb_data[k*psum_bw +: psum_bw] = (last_r && lane_sat[psum_bw-1]) ? '0 : lane_sat;
    end

    // Write data is formed from registered vec_r and the SRAM's registered read port,
    // so it only moves at clock edges while still folding in the word read in RD.
    assign pmem_d = pmem_wen ? '0 : wb_data;

endmodule

// File: tb/tb_psum_accum_wb.sv
// tb/tb_psum_accum_wb.sv - directed table-driven bench for psum_accum_wb
module tb_psum_accum_wb;

    localparam int psum_bw    = 16;
    localparam int col        = 8;
    localparam int addr_width = 11;
    localparam int dw         = psum_bw * col;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [addr_width-1:0]  num_vec;
    logic [addr_width-1:0]  base_addr;
    logic                   first_pass;
    logic                   last_pass;
    logic                   in_valid;
    logic [dw-1:0]          in_data;
    logic                   in_ready;
    logic                   pmem_cen;
    logic                   pmem_wen;
    logic [addr_width-1:0]  pmem_addr;
    logic [dw-1:0]          pmem_d;
    logic [dw-1:0]          pmem_q;
    logic                   busy;
    logic                   done;

    psum_accum_wb #(.psum_bw(psum_bw), .col(col), .addr_width(addr_width)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
        .base_addr(base_addr), .first_pass(first_pass), .last_pass(last_pass),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
        .pmem_d(pmem_d), .pmem_q(pmem_q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [dw-1:0]          mem [0:2047];
    logic                   pre_en = 1'b0;
    logic [addr_width-1:0]  pre_addr = '0;
    logic [dw-1:0]          pre_data = '0;
    int                     cyc = 0;
    int                     wr_cnt = 0;
    int                     rd_cnt = 0;
    int                     done_cnt = 0;
    int                     done_cyc = 0;
    int                     acc_cyc = 0;
    int                     bad_ready = 0;
    int                     wr_cyc_log [0:255];
    logic [addr_width-1:0]  wr_addr_log [0:255];
    int                     n_vec = 0;
    int                     n_bad = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (!pmem_cen) begin
            if (!pmem_wen) mem[pmem_addr] <= pmem_d;
            else           pmem_q <= mem[pmem_addr];
        end
    end

    always @(negedge clk) begin
        if (!pmem_cen && !pmem_wen) begin
            wr_addr_log[wr_cnt % 256] <= pmem_addr;
            wr_cyc_log[wr_cnt % 256]  <= cyc;
            wr_cnt <= wr_cnt + 1;
        end
        if (!pmem_cen && pmem_wen) rd_cnt <= rd_cnt + 1;
        if (in_valid && in_ready) acc_cyc <= cyc;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (!pmem_cen && in_ready) bad_ready <= bad_ready + 1;
    end

    typedef struct {
        logic                   fp;
        logic                   lp;
        logic [addr_width-1:0]  base;
        logic [15:0]            stored;
        logic [15:0]            inp;
        int                     step;
        logic [15:0]            expv;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [dw-1:0] rep(input logic [15:0] v, input int step);
        logic [dw-1:0] r;
        for (int k = 0; k < col; k++) r[k*psum_bw +: psum_bw] = v + 16'(k * step);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [dw-1:0] got, input logic [dw-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic preload(input logic [addr_width-1:0] a, input logic [dw-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic start_run(input logic fp, input logic lp, input logic [addr_width-1:0] b,
                             input logic [addr_width-1:0] n, output int s_cyc);
        @(negedge clk);
        first_pass = fp;
        last_pass  = lp;
        base_addr  = b;
        num_vec    = n;
        start      = 1'b1;
        s_cyc      = cyc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic feed(input logic [dw-1:0] v);
        bit ok;
        ok       = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("feed_accept", dw'(ok), dw'(1));
    endtask

    task automatic wait_done(input string nm, input int d0);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, "_done"}, dw'(seen), dw'(1));
    endtask

    initial begin
        int d0, w0, r0, s_cyc, hold_ok;
        logic [15:0] rst_pins;

        tbl[0] = '{1'b1, 1'b0, 11'd10, 16'd1234,    16'd7,       5, 16'd7};
        tbl[1] = '{1'b0, 1'b0, 11'd5,  16'd100,     16'(-30),    3, 16'd70};
        tbl[2] = '{1'b0, 1'b0, 11'd20, 16'd32000,   16'd1000,    0, 16'd32767};
        tbl[3] = '{1'b0, 1'b1, 11'd21, 16'(-32000), 16'(-1000),  0, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 11'd22, 16'(-5),     16'd3,       0, 16'(-2)};
        tbl[5] = '{1'b1, 1'b1, 11'd23, 16'd55,      16'(-9),     0, 16'd0};
        tbl[6] = '{1'b1, 1'b1, 11'd24, 16'd55,      16'd9,       2, 16'd9};
        tbl[7] = '{1'b0, 1'b0, 11'd25, 16'h8000,    16'(-1),     0, 16'h8000};
        tbl[8] = '{1'b0, 1'b1, 11'd26, 16'd20,      16'd22,      1, 16'd42};
        tbl[9] = '{1'b0, 1'b0, 11'd27, 16'd32767,   16'h8000,    0, 16'(-1)};

        reset = 1'b1; start = 1'b0; num_vec = '0; base_addr = '0;
        first_pass = 1'b0; last_pass = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        rst_pins = {in_ready, pmem_cen, pmem_wen, pmem_addr, busy, done};
        chk("reset_pins", dw'(rst_pins), dw'({1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0}));
        chk("reset_pmem_d", pmem_d, '0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            preload(tbl[i].base, rep(tbl[i].stored, 0));
            d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
            start_run(tbl[i].fp, tbl[i].lp, tbl[i].base, 11'd1, s_cyc);
            feed(rep(tbl[i].inp, tbl[i].step));
            wait_done("vec", d0);
            chk("vec_data", mem[tbl[i].base], rep(tbl[i].expv, tbl[i].step));
            chk("vec_addr", dw'(wr_addr_log[w0 % 256]), dw'(tbl[i].base));
            chk("vec_latency", dw'(wr_cyc_log[w0 % 256] - acc_cyc), dw'(tbl[i].fp ? 1 : 2));
            chk("vec_reads", dw'(rd_cnt - r0), dw'(tbl[i].fp ? 0 : 1));
        end

        d0 = done_cnt; w0 = wr_cnt;
        start_run(1'b1, 1'b0, 11'd5, 11'd3, s_cyc);
        feed(rep(16'd1, 0));
        feed(rep(16'd2, 0));
        feed(rep(16'd3, 0));
        wait_done("fp_run", d0);
        chk("fp_mem5", mem[5], rep(16'd1, 0));
        chk("fp_mem6", mem[6], rep(16'd2, 0));
        chk("fp_mem7", mem[7], rep(16'd3, 0));
        chk("fp_writes", dw'(wr_cnt - w0), dw'(3));
        chk("fp_gap01", dw'(wr_cyc_log[(w0 + 1) % 256] - wr_cyc_log[w0 % 256]), dw'(2));
        chk("fp_gap12", dw'(wr_cyc_log[(w0 + 2) % 256] - wr_cyc_log[(w0 + 1) % 256]), dw'(2));
        chk("fp_done_lag", dw'(done_cyc - wr_cyc_log[(w0 + 2) % 256]), dw'(1));

        preload(11'd100, rep(16'd500, 0));
        start_run(1'b0, 1'b0, 11'd100, 11'd2, s_cyc);
        feed(rep(16'd9, 0));
        chk("rst_rd_pins", dw'({pmem_cen, pmem_wen, pmem_addr}), dw'({1'b0, 1'b1, 11'd100}));
        reset = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        #1;
        rst_pins = {in_ready, pmem_cen, pmem_wen, pmem_addr, busy, done};
        chk("rst_mid_pins", dw'(rst_pins), dw'({1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0}));
        chk("rst_mid_nowrite", dw'(wr_cnt - w0), dw'(0));
        chk("rst_mid_mem", mem[100], rep(16'd500, 0));
        reset = 1'b0;
        d0 = done_cnt;
        start_run(1'b1, 1'b0, 11'd100, 11'd1, s_cyc);
        feed(rep(16'd77, 0));
        wait_done("rst_restart", d0);
        chk("rst_restart_mem", mem[100], rep(16'd77, 0));

        d0 = done_cnt; w0 = wr_cnt;
        start_run(1'b1, 1'b0, 11'd2046, 11'd3, s_cyc);
        feed(rep(16'd11, 0));
        feed(rep(16'd12, 0));
        feed(rep(16'd13, 0));
        wait_done("wrap", d0);
        chk("wrap_addr0", dw'(wr_addr_log[w0 % 256]), dw'(2046));
        chk("wrap_addr1", dw'(wr_addr_log[(w0 + 1) % 256]), dw'(2047));
        chk("wrap_addr2", dw'(wr_addr_log[(w0 + 2) % 256]), dw'(0));
        chk("wrap_mem0", mem[0], rep(16'd13, 0));
        chk("wrap_mem2047", mem[2047], rep(16'd12, 0));

        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
        start_run(1'b0, 1'b0, 11'd500, 11'd0, s_cyc);
        wait_done("zero", d0);
        chk("zero_done_lag", dw'(done_cyc - s_cyc), dw'(1));
        chk("zero_nowrite", dw'(wr_cnt - w0), dw'(0));
        chk("zero_noread", dw'(rd_cnt - r0), dw'(0));
        @(negedge clk);
        chk("zero_busy_low", dw'(busy), dw'(0));

        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
        start_run(1'b1, 1'b0, 11'd300, 11'd2, s_cyc);
        hold_ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready && pmem_cen && busy) hold_ok++;
            @(negedge clk);
        end
        chk("bp_hold", dw'(hold_ok), dw'(10));
        chk("bp_noaccess", dw'((wr_cnt - w0) + (rd_cnt - r0)), dw'(0));
        first_pass = 1'b0; base_addr = 11'd0; num_vec = 11'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(rep(16'd41, 1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(rep(16'd42, 1));
        wait_done("bp", d0);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_mem300", mem[300], rep(16'd41, 1));
        chk("bp_mem301", mem[301], rep(16'd42, 1));
        chk("bp_writes", dw'(wr_cnt - w0), dw'(2));
        chk("bp_addr1", dw'(wr_addr_log[(w0 + 1) % 256]), dw'(301));
        chk("bp_one_done", dw'(done_cnt - d0), dw'(1));
        chk("ready_in_rdwr", dw'(bad_ready), dw'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
